// File: rtl/hwpe_stream_sync_fifo_pkg.sv
// Shared HWPE-Stream types: FIFO flag bundle and FIFO occupancy state.
package hwpe_stream_package;

  // Pointer fields are fixed-width so the struct can live in a package; they are zero-extended.
  typedef struct packed {
    logic       empty;
    logic       full;
    logic [7:0] push_pointer;
    logic [7:0] pop_pointer;
  } flags_fifo_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    MIDDLE = 2'd1,
    FULL   = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/hwpe_stream_sync_fifo_if.sv
// HWPE-Stream valid/ready channel carrying data plus byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input  ready);
  modport sink   (input  valid, input  data, input  strb, output ready);
endinterface

// File: rtl/hwpe_stream_sync_fifo_mem.sv
// FIFO storage: one write port, one asynchronous read port; flip-flop or latch array.
module hwpe_stream_fifo_mem #(
  parameter int unsigned WIDTH      = 36,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LATCH_FIFO = 0,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  if (LATCH_FIFO == 0) begin : g_ff
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        mem_q <= '{default: '0};
      end else if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
    end

    assign rdata_o = mem_q[raddr_i];
  end else begin : g_latch
    logic [WIDTH-1:0] wdata_q;
    logic [DEPTH-1:0] we_q;
    logic [WIDTH-1:0] mem_l [DEPTH];

    // Write data is staged on the rising edge, then the selected latch opens in the low phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wdata_q <= '0;
        we_q    <= '0;
      end else begin
        we_q <= '0;
        if (we_i) begin
          wdata_q        <= wdata_i;
          we_q[waddr_i]  <= 1'b1;
        end
      end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      always_latch begin
        if (!clk_i && we_q[i]) begin
          mem_l[i] <= wdata_q;
        end
      end
    end

    assign rdata_o = mem_l[raddr_i];
  end

endmodule

// File: rtl/hwpe_stream_sync_fifo.sv
// Synchronous HWPE-Stream FIFO, no fall-through. SVA checks under HWPE_STREAM_FIFO_ASSERTIONS_EN.
//   state  | meaning
//   EMPTY  | no words stored, pop_o.valid low
//   MIDDLE | 1 .. FIFO_DEPTH-1 words stored
//   FULL   | FIFO_DEPTH words stored, push_i.ready low
module hwpe_stream_sync_fifo
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LATCH_FIFO = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  output flags_fifo_t             flags_o,
  hwpe_stream_intf_stream.sink    push_i,
  hwpe_stream_intf_stream.source  pop_o
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  fifo_state_e state_q, state_d;
  logic [AW-1:0] push_ptr_q, push_ptr_d;
  logic [AW-1:0] pop_ptr_q,  pop_ptr_d;
  logic          push_hs, pop_hs;
  logic [DATA_WIDTH+STRB_W-1:0] rdata;

  assign push_i.ready = (state_q != FULL);
  assign pop_o.valid  = (state_q != EMPTY);
  assign push_hs      = push_i.valid & push_i.ready;
  assign pop_hs       = pop_o.valid & pop_o.ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      push_ptr_q <= '0;
      pop_ptr_q  <= '0;
    end else begin
      state_q    <= state_d;
      push_ptr_q <= push_ptr_d;
      pop_ptr_q  <= pop_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    push_ptr_d = push_ptr_q;
    pop_ptr_d  = pop_ptr_q;
    if (clear_i) begin
      state_d    = EMPTY;
      push_ptr_d = '0;
      pop_ptr_d  = '0;
    end else begin
      if (push_hs) push_ptr_d = push_ptr_q + PTR_ONE;
      if (pop_hs)  pop_ptr_d  = pop_ptr_q + PTR_ONE;
      unique case (state_q)
        EMPTY: begin
          if (push_hs) state_d = MIDDLE;
        end
        MIDDLE: begin
          if (push_hs && !pop_hs && (push_ptr_d == pop_ptr_q)) begin
            state_d = FULL;
          end else if (pop_hs && !push_hs && (pop_ptr_d == push_ptr_q)) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop_hs) state_d = MIDDLE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // A push coinciding with clear is dropped, so the array must not be written either.
  hwpe_stream_fifo_mem #(
    .WIDTH      (DATA_WIDTH + STRB_W),
    .DEPTH      (FIFO_DEPTH),
    .LATCH_FIFO (LATCH_FIFO)
  ) i_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (push_hs & ~clear_i),
    .waddr_i (push_ptr_q),
    .wdata_i ({push_i.data, push_i.strb}),
    .raddr_i (pop_ptr_q),
    .rdata_o (rdata)
  );

  assign pop_o.data = rdata[DATA_WIDTH+STRB_W-1:STRB_W];
  assign pop_o.strb = rdata[STRB_W-1:0];

  assign flags_o.empty        = (state_q == EMPTY);
  assign flags_o.full         = (state_q == FULL);
  assign flags_o.push_pointer = 8'(push_ptr_q);
  assign flags_o.pop_pointer  = 8'(pop_ptr_q);

`ifdef HWPE_STREAM_FIFO_ASSERTIONS_EN
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i.valid && push_i.ready && flags_o.full));

  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_o.valid && pop_o.ready && flags_o.empty));

  a_push_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push_i.valid && !push_i.ready) |=>
      (push_i.valid && $stable(push_i.data) && $stable(push_i.strb)));
`endif

endmodule

// File: tb/tb_hwpe_stream_sync_fifo.sv
// Scoreboard bench for hwpe_stream_sync_fifo: accepted pushes queue expectations, a pop monitor checks them.
module tb_hwpe_stream_sync_fifo;
  import hwpe_stream_package::*;

  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b0;
  logic        clear_i = 1'b0;
  flags_fifo_t flags;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop_if ();

  always #5 clk_i = ~clk_i;

  hwpe_stream_sync_fifo #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (8),
    .LATCH_FIFO (0)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .flags_o (flags),
    .push_i  (push_if),
    .pop_o   (pop_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_rx  = 0;
  logic [DW+SW-1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  // Expected stream: every word the bench drove that the FIFO accepted.
  always @(negedge clk_i) begin
    if (rst_ni && push_if.valid && push_if.ready && !clear_i)
      exp_q.push_back({push_if.data, push_if.strb});
  end

  always @(negedge clk_i) begin
    if (rst_ni && pop_if.valid && pop_if.ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pop: got 0x%0h with no word outstanding", pop_if.data);
      end else begin
        logic [DW+SW-1:0] e;
        e = exp_q.pop_front();
        chk("pop_data", 64'(pop_if.data), 64'(e[DW+SW-1:SW]));
        chk("pop_strb", 64'(pop_if.strb), 64'(e[SW-1:0]));
        n_rx++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic push_word(input logic [DW-1:0] d, input logic [SW-1:0] s);
    int t;
    t = 0;
    push_if.valid = 1'b1;
    push_if.data  = d;
    push_if.strb  = s;
    forever begin
      @(negedge clk_i);
      if (push_if.ready) break;
      t++;
      if (t > 200) begin
        fail("push_timeout");
        break;
      end
    end
    @(posedge clk_i);
    #1;
    push_if.valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (t < 400 && !(exp_q.size() == 0 && flags.empty)) begin
      @(negedge clk_i);
      t++;
    end
    if (!(exp_q.size() == 0 && flags.empty)) fail(name);
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 64'(push_if.ready), 64'd1);
    chk({tag, "_valid"}, 64'(pop_if.valid), 64'd0);
    chk({tag, "_empty"}, 64'(flags.empty), 64'd1);
    chk({tag, "_full"},  64'(flags.full), 64'd0);
    chk({tag, "_push_ptr"}, 64'(flags.push_pointer), 64'd0);
    chk({tag, "_pop_ptr"},  64'(flags.pop_pointer), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit done;
  int rx0;

  initial begin
    push_if.valid = 1'b0;
    push_if.data  = '0;
    push_if.strb  = '0;
    pop_if.ready  = 1'b0;

    // Reset
    repeat (20) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk_idle("reset");
    @(posedge clk_i);
    #1;

    // Fill 0..7 with the consumer stalled
    for (int i = 0; i < 8; i++) push_word(DW'(i), SW'(i) ^ 4'hF);
    chk("fill_full", 64'(flags.full), 64'd1);
    chk("fill_ready", 64'(push_if.ready), 64'd0);
    chk("fill_valid", 64'(pop_if.valid), 64'd1);
    chk("fill_push_ptr", 64'(flags.push_pointer), 64'd0);
    push_if.valid = 1'b1;
    push_if.data  = 32'h8;
    push_if.strb  = 4'h7;
    repeat (3) @(posedge clk_i);
    #1;
    chk("hold_full", 64'(flags.full), 64'd1);
    chk("hold_not_accepted", 64'(exp_q.size()), 64'd8);

    // Drain: 0..7 then the held 0x8
    rx0 = n_rx;
    pop_if.ready = 1'b1;
    push_word(32'h8, 4'h7);
    wait_drain("drain_timeout");
    chk("drain_count", 64'(n_rx - rx0), 64'd9);
    chk("drain_empty", 64'(flags.empty), 64'd1);
    chk("drain_pop_ptr_wrap", 64'(flags.pop_pointer), 64'd1);
    chk("drain_push_ptr", 64'(flags.push_pointer), 64'd1);

    // Clear with a simultaneous push
    pop_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'h100 + DW'(i), 4'hC);
    chk("pre_clear_push_ptr", 64'(flags.push_pointer), 64'd6);
    clear_i       = 1'b1;
    push_if.valid = 1'b1;
    push_if.data  = 32'hDEAD_BEEF;
    push_if.strb  = 4'h9;
    @(posedge clk_i);
    #1;
    clear_i       = 1'b0;
    push_if.valid = 1'b0;
    chk_idle("clear");
    exp_q.delete();
    pop_if.ready = 1'b1;
    push_word(32'h55, 4'h5);
    wait_drain("post_clear_timeout");

    // Reset mid-stream with 3 words stored and the producer active
    pop_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'h200 + DW'(i), 4'h3);
    push_if.valid = 1'b1;
    push_if.data  = 32'h77;
    #3 rst_ni = 1'b0;
    #1;
    chk("async_rst_ready", 64'(push_if.ready), 64'd1);
    chk("async_rst_valid", 64'(pop_if.valid), 64'd0);
    chk("async_rst_empty", 64'(flags.empty), 64'd1);
    exp_q.delete();
    repeat (10) @(posedge clk_i);
    #1;
    push_if.valid = 1'b0;
    rst_ni        = 1'b1;
    @(negedge clk_i);
    chk_idle("mid_rst");
    @(posedge clk_i);
    #1;
    rx0 = n_rx;
    pop_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'h300 + DW'(i), SW'(i + 1));
    wait_drain("post_rst_timeout");
    chk("post_rst_count", 64'(n_rx - rx0), 64'd4);

    // Random stalls on both sides, 1024 words
    rx0  = n_rx;
    done = 1'b0;
    fork
      begin
        while (!done) begin
          pop_if.ready = ($urandom_range(9) != 0);
          @(posedge clk_i);
          #1;
        end
      end
      begin
        for (int i = 0; i < 1024; i++) begin
          while ($urandom_range(9) == 0) begin
            @(posedge clk_i);
            #1;
          end
          push_word(32'hA500_0000 ^ (DW'(i) * 32'h9E37), SW'(i * 7));
        end
        done = 1'b1;
      end
    join
    pop_if.ready = 1'b1;
    wait_drain("random_timeout");
    chk("random_count", 64'(n_rx - rx0), 64'd1024);
    chk("random_empty", 64'(flags.empty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
